// File: rtl/cpu_types_pkg.sv
// Shared types for the Decode/Execute boundary.
//   word_t, regbits_t : data/PC word and register-index types
//   aluop_t           : ALU operation select
//   regdst_t, memtoreg_t, alusrc_t : control select encodings
//   idex_ctrl_t       : control bundle carried through ID/EX
//   IDEX_BUBBLE       : control value of an inserted bubble
package cpu_types_pkg;

    localparam int REG_W  = 5;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'h0,
        ALU_SRL  = 4'h1,
        ALU_ADD  = 4'h2,
        ALU_SUB  = 4'h3,
        ALU_AND  = 4'h4,
        ALU_OR   = 4'h5,
        ALU_XOR  = 4'h6,
        ALU_NOR  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } aluop_t;

    typedef enum logic [1:0] {
        REGDST_RD = 2'd0,
        REGDST_RT = 2'd1,
        REGDST_RA = 2'd2
    } regdst_t;

    typedef enum logic [1:0] {
        MTR_ALU = 2'd0,
        MTR_MEM = 2'd1,
        MTR_PC  = 2'd2,
        MTR_LUI = 2'd3
    } memtoreg_t;

    typedef enum logic [1:0] {
        ALUSRC_REG   = 2'd0,
        ALUSRC_IMM   = 2'd1,
        ALUSRC_SHAMT = 2'd2
    } alusrc_t;

    typedef struct packed {
        logic      valid;
        logic      RegWr;
        logic      MemRead;
        logic      MemWrite;
        logic      branch;
        logic      jump;
        logic      halt;
        regdst_t   RegDst;
        memtoreg_t MemToReg;
        alusrc_t   ALUSrc;
        aluop_t    ALUOp;
    } idex_ctrl_t;

    localparam idex_ctrl_t IDEX_BUBBLE = '{
        valid:    1'b0,
        RegWr:    1'b0,
        MemRead:  1'b0,
        MemWrite: 1'b0,
        branch:   1'b0,
        jump:     1'b0,
        halt:     1'b0,
        RegDst:   REGDST_RD,
        MemToReg: MTR_ALU,
        ALUSrc:   ALUSRC_REG,
        ALUOp:    ALU_SLL
    };

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare.
//   ex_valid, ex_MemRead, ex_RegDst, ex_rt, ex_rd : instruction in EX
//   id_valid, id_rs, id_rt, id_uses_rt            : instruction in decode
//   load_use : high when decode reads the register the EX load writes
module load_use_detect
    import cpu_types_pkg::*;
#(
    parameter int REGW = REG_W
) (
    input  logic            ex_valid,
    input  logic            ex_MemRead,
    input  regdst_t         ex_RegDst,
    input  logic [REGW-1:0] ex_rt,
    input  logic [REGW-1:0] ex_rd,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_uses_rt,
    output logic            load_use
);

    logic [REGW-1:0] ex_dest;

    // The unused select encoding writes no register, so it never stalls.
    always_comb begin
        ex_dest = '0;
        case (ex_RegDst)
            REGDST_RD: ex_dest = ex_rd;
            REGDST_RT: ex_dest = ex_rt;
            REGDST_RA: ex_dest = REGW'(31);
            default:   ex_dest = '0;
        endcase
    end

    // $0 is hardwired, so a load "to" it creates no dependency.
    assign load_use = ex_valid && ex_MemRead && id_valid && (ex_dest != '0) &&
                      ((id_rs == ex_dest) || (id_uses_rt && (id_rt == ex_dest)));

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use bubble insertion.
//   CLK, nRST       : clock, async active-low reset
//   en, flush       : advance enable, squash (flush wins over everything)
//   id_*            : decoded instruction fields
//   ex_*, ex_valid  : registered copies presented to Execute
//   load_use        : zero-latency hazard flag, holds PC and IF/ID
module id_ex_latch
    import cpu_types_pkg::*;
#(
    parameter int REGW  = REG_W,
    parameter int WORDW = WORD_W
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [WORDW-1:0] id_pc,
    input  logic [WORDW-1:0] id_rdat1,
    input  logic [WORDW-1:0] id_rdat2,
    input  logic [WORDW-1:0] id_imm,
    input  logic [REGW-1:0]  id_rs,
    input  logic [REGW-1:0]  id_rt,
    input  logic [REGW-1:0]  id_rd,
    input  logic             id_uses_rt,
    input  logic [1:0]       id_RegDst,
    input  logic             id_RegWr,
    input  logic             id_MemRead,
    input  logic             id_MemWrite,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic             id_halt,
    input  logic [1:0]       id_MemToReg,
    input  logic [1:0]       id_ALUSrc,
    input  logic [3:0]       id_ALUOp,
    output logic             ex_valid,
    output logic [WORDW-1:0] ex_pc,
    output logic [WORDW-1:0] ex_rdat1,
    output logic [WORDW-1:0] ex_rdat2,
    output logic [WORDW-1:0] ex_imm,
    output logic [REGW-1:0]  ex_rs,
    output logic [REGW-1:0]  ex_rt,
    output logic [REGW-1:0]  ex_rd,
    output logic             ex_uses_rt,
    output logic [1:0]       ex_RegDst,
    output logic             ex_RegWr,
    output logic             ex_MemRead,
    output logic             ex_MemWrite,
    output logic             ex_branch,
    output logic             ex_jump,
    output logic             ex_halt,
    output logic [1:0]       ex_MemToReg,
    output logic [1:0]       ex_ALUSrc,
    output logic [3:0]       ex_ALUOp,
    output logic             load_use
);

    idex_ctrl_t       ctrl_q;
    idex_ctrl_t       ctrl_d;
    logic [WORDW-1:0] pc_q, rdat1_q, rdat2_q, imm_q;
    logic [REGW-1:0]  rs_q, rt_q, rd_q;
    logic             uses_rt_q;
    logic             bubble;

    load_use_detect #(.REGW(REGW)) u_load_use_detect (
        .ex_valid   (ctrl_q.valid),
        .ex_MemRead (ctrl_q.MemRead),
        .ex_RegDst  (ctrl_q.RegDst),
        .ex_rt      (rt_q),
        .ex_rd      (rd_q),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .load_use   (load_use)
    );

    always_comb begin
        ctrl_d          = IDEX_BUBBLE;
        ctrl_d.valid    = id_valid;
        ctrl_d.RegWr    = id_RegWr;
        ctrl_d.MemRead  = id_MemRead;
        ctrl_d.MemWrite = id_MemWrite;
        ctrl_d.branch   = id_branch;
        ctrl_d.jump     = id_jump;
        ctrl_d.halt     = id_halt;
        ctrl_d.RegDst   = regdst_t'(id_RegDst);
        ctrl_d.MemToReg = memtoreg_t'(id_MemToReg);
        ctrl_d.ALUSrc   = alusrc_t'(id_ALUSrc);
        ctrl_d.ALUOp    = aluop_t'(id_ALUOp);
    end

    // A stalled pipeline (en=0) holds even under load_use; the bubble waits
    // for the first advancing edge. Flush squashes regardless of en.
    assign bubble = flush || (en && load_use);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ctrl_q    <= IDEX_BUBBLE;
            pc_q      <= '0;
            rdat1_q   <= '0;
            rdat2_q   <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            uses_rt_q <= 1'b0;
        end else if (bubble) begin
            ctrl_q    <= IDEX_BUBBLE;
            pc_q      <= '0;
            rdat1_q   <= '0;
            rdat2_q   <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            uses_rt_q <= 1'b0;
        end else if (en) begin
            ctrl_q    <= ctrl_d;
            pc_q      <= id_pc;
            rdat1_q   <= id_rdat1;
            rdat2_q   <= id_rdat2;
            imm_q     <= id_imm;
            rs_q      <= id_rs;
            rt_q      <= id_rt;
            rd_q      <= id_rd;
            uses_rt_q <= id_uses_rt;
        end
    end

    assign ex_valid    = ctrl_q.valid;
    assign ex_RegWr    = ctrl_q.RegWr;
    assign ex_MemRead  = ctrl_q.MemRead;
    assign ex_MemWrite = ctrl_q.MemWrite;
    assign ex_branch   = ctrl_q.branch;
    assign ex_jump     = ctrl_q.jump;
    assign ex_halt     = ctrl_q.halt;
    assign ex_RegDst   = ctrl_q.RegDst;
    assign ex_MemToReg = ctrl_q.MemToReg;
    assign ex_ALUSrc   = ctrl_q.ALUSrc;
    assign ex_ALUOp    = ctrl_q.ALUOp;
    assign ex_pc       = pc_q;
    assign ex_rdat1    = rdat1_q;
    assign ex_rdat2    = rdat2_q;
    assign ex_imm      = imm_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_rd       = rd_q;
    assign ex_uses_rt  = uses_rt_q;

endmodule

// File: tb/tb_id_ex_latch.sv
module tb_id_ex_latch;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        en, flush, id_valid;
    logic [31:0] id_pc, id_rdat1, id_rdat2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_uses_rt;
    logic [1:0]  id_RegDst;
    logic        id_RegWr, id_MemRead, id_MemWrite, id_branch, id_jump, id_halt;
    logic [1:0]  id_MemToReg, id_ALUSrc;
    logic [3:0]  id_ALUOp;

    logic        ex_valid;
    logic [31:0] ex_pc, ex_rdat1, ex_rdat2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        ex_uses_rt;
    logic [1:0]  ex_RegDst;
    logic        ex_RegWr, ex_MemRead, ex_MemWrite, ex_branch, ex_jump, ex_halt;
    logic [1:0]  ex_MemToReg, ex_ALUSrc;
    logic [3:0]  ex_ALUOp;
    logic        load_use;

    int total = 0;
    int bad   = 0;

    logic [160:0] ex_all;
    assign ex_all = {ex_valid, ex_pc, ex_rdat1, ex_rdat2, ex_imm, ex_rs, ex_rt, ex_rd,
                     ex_uses_rt, ex_RegDst, ex_RegWr, ex_MemRead, ex_MemWrite, ex_branch,
                     ex_jump, ex_halt, ex_MemToReg, ex_ALUSrc, ex_ALUOp};

    always #5 CLK = ~CLK;

    id_ex_latch dut (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_RegDst(id_RegDst), .id_RegWr(id_RegWr), .id_MemRead(id_MemRead),
        .id_MemWrite(id_MemWrite), .id_branch(id_branch), .id_jump(id_jump),
        .id_halt(id_halt), .id_MemToReg(id_MemToReg), .id_ALUSrc(id_ALUSrc),
        .id_ALUOp(id_ALUOp),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rdat1(ex_rdat1), .ex_rdat2(ex_rdat2),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_uses_rt(ex_uses_rt), .ex_RegDst(ex_RegDst), .ex_RegWr(ex_RegWr),
        .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_halt(ex_halt), .ex_MemToReg(ex_MemToReg),
        .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .load_use(load_use)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        en = 0; flush = 0; id_valid = 0;
        id_pc = 0; id_rdat1 = 0; id_rdat2 = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rt = 0; id_RegDst = 0;
        id_RegWr = 0; id_MemRead = 0; id_MemWrite = 0; id_branch = 0; id_jump = 0;
        id_halt = 0; id_MemToReg = 0; id_ALUSrc = 0; id_ALUOp = 0;
    endtask

    // Advance a valid load into EX; it writes register dst via RegDst sel.
    task automatic load_lw(input logic [4:0] dst, input logic [1:0] sel);
        idle_inputs();
        en = 1; id_valid = 1; id_MemRead = 1; id_RegWr = 1; id_MemToReg = 2'd1;
        id_ALUSrc = 2'd1; id_ALUOp = 4'h2; id_RegDst = sel; id_rdat1 = 32'hA0;
        if (sel == 2'd0) id_rd = dst; else id_rt = dst;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 nRST = 0;
        #1;
        total++; if (ex_all !== '0) begin bad++; $display("FAIL reset_initial got=%h exp=0", ex_all); end
        tick();
        nRST = 1;
        en = 1; id_valid = 1; id_RegWr = 1; id_rdat1 = 32'hDEAD;
        tick();
        total++; if (ex_RegWr !== 1'b1) begin bad++; $display("FAIL reset_preload_regwr got=%b exp=1", ex_RegWr); end
        total++; if (ex_rdat1 !== 32'hDEAD) begin bad++; $display("FAIL reset_preload_rdat1 got=%h exp=dead", ex_rdat1); end
        #2 nRST = 0;
        #1;
        total++; if (ex_all !== '0) begin bad++; $display("FAIL reset_async got=%h exp=0", ex_all); end
        total++; if (load_use !== 1'b0) begin bad++; $display("FAIL reset_load_use got=%b exp=0", load_use); end
        #1 nRST = 1;
        idle_inputs();
        tick();
    endtask

    task automatic test_advance();
        idle_inputs();
        en = 1; id_valid = 1; id_rs = 3; id_rdat1 = 32'h1234; id_RegWr = 1;
        id_pc = 32'h0000_0104; id_rdat2 = 32'h5678; id_imm = 32'hFFFF_FFF0;
        id_rt = 5'd7; id_rd = 5'd12; id_uses_rt = 1; id_RegDst = 2'd2;
        id_MemWrite = 1; id_branch = 1; id_jump = 1; id_halt = 1;
        id_MemToReg = 2'd2; id_ALUSrc = 2'd1; id_ALUOp = 4'h9;
        #1;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL adv_latency got=%b exp=0", ex_valid); end
        tick();
        total++; if (ex_rs !== 5'd3) begin bad++; $display("FAIL adv_rs got=%0d exp=3", ex_rs); end
        total++; if (ex_rdat1 !== 32'h1234) begin bad++; $display("FAIL adv_rdat1 got=%h exp=1234", ex_rdat1); end
        total++; if (ex_RegWr !== 1'b1) begin bad++; $display("FAIL adv_regwr got=%b exp=1", ex_RegWr); end
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL adv_valid got=%b exp=1", ex_valid); end
        total++;
        if (ex_all !== {1'b1, 32'h0000_0104, 32'h1234, 32'h5678, 32'hFFFF_FFF0, 5'd3, 5'd7, 5'd12,
                        1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 2'd1, 4'h9}) begin
            bad++; $display("FAIL adv_all_fields got=%h", ex_all);
        end
    endtask

    task automatic test_load_use_rs();
        load_lw(5'd8, 2'd1);
        idle_inputs();
        en = 1; id_valid = 1; id_rs = 8; id_rt = 2; id_rd = 9; id_uses_rt = 1;
        id_RegWr = 1; id_rdat1 = 32'h55; id_ALUOp = 4'h2;
        #1;
        total++; if (load_use !== 1'b1) begin bad++; $display("FAIL lu_rs_flag got=%b exp=1", load_use); end
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble_valid got=%b exp=0", ex_valid); end
        total++; if (ex_MemRead !== 1'b0) begin bad++; $display("FAIL lu_bubble_memread got=%b exp=0", ex_MemRead); end
        total++; if (ex_all !== '0) begin bad++; $display("FAIL lu_bubble_all got=%h exp=0", ex_all); end
        total++; if (load_use !== 1'b0) begin bad++; $display("FAIL lu_clears got=%b exp=0", load_use); end
        tick();
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL lu_reissue_valid got=%b exp=1", ex_valid); end
        total++; if (ex_rs !== 5'd8) begin bad++; $display("FAIL lu_reissue_rs got=%0d exp=8", ex_rs); end
        total++; if (ex_rd !== 5'd9) begin bad++; $display("FAIL lu_reissue_rd got=%0d exp=9", ex_rd); end
        total++; if (ex_rdat1 !== 32'h55) begin bad++; $display("FAIL lu_reissue_rdat1 got=%h exp=55", ex_rdat1); end
    endtask

    task automatic test_no_false_hazard();
        load_lw(5'd0, 2'd1);
        idle_inputs();
        id_valid = 1; id_rs = 0;
        #1;
        total++; if (load_use !== 1'b0) begin bad++; $display("FAIL nfh_dest0 got=%b exp=0", load_use); end
        load_lw(5'd8, 2'd1);
        idle_inputs();
        id_valid = 1; id_rs = 1; id_rt = 8; id_uses_rt = 0;
        #1;
        total++; if (load_use !== 1'b0) begin bad++; $display("FAIL nfh_rt_unused got=%b exp=0", load_use); end
        id_uses_rt = 1;
        #1;
        total++; if (load_use !== 1'b1) begin bad++; $display("FAIL nfh_rt_used got=%b exp=1", load_use); end
        id_valid = 0;
        #1;
        total++; if (load_use !== 1'b0) begin bad++; $display("FAIL nfh_id_invalid got=%b exp=0", load_use); end
        load_lw(5'd31, 2'd2);
        idle_inputs();
        id_valid = 1; id_rs = 31;
        #1;
        total++; if (load_use !== 1'b1) begin bad++; $display("FAIL nfh_ra_dest got=%b exp=1", load_use); end
        load_lw(5'd6, 2'd0);
        idle_inputs();
        id_valid = 1; id_rs = 6;
        #1;
        total++; if (load_use !== 1'b1) begin bad++; $display("FAIL nfh_rd_dest got=%b exp=1", load_use); end
    endtask

    task automatic test_stall_hold();
        load_lw(5'd8, 2'd1);
        idle_inputs();
        en = 0; id_valid = 1; id_rs = 8; id_RegWr = 1;
        for (int i = 0; i < 3; i++) begin
            id_rdat1 = 32'h100 + 32'(i);
            id_rd = 5'(10 + i);
            #1;
            total++; if (load_use !== 1'b1) begin bad++; $display("FAIL stall_flag_%0d got=%b exp=1", i, load_use); end
            tick();
            total++;
            if ({ex_valid, ex_MemRead, ex_rt, ex_rdat1, ex_rd} !== {1'b1, 1'b1, 5'd8, 32'hA0, 5'd0}) begin
                bad++; $display("FAIL stall_hold_%0d got=%b/%b/%0d/%h/%0d exp=1/1/8/a0/0",
                                i, ex_valid, ex_MemRead, ex_rt, ex_rdat1, ex_rd);
            end
        end
        en = 1;
        tick();
        total++; if (ex_all !== '0) begin bad++; $display("FAIL stall_release_bubble got=%h exp=0", ex_all); end
    endtask

    task automatic test_flush_priority();
        load_lw(5'd8, 2'd1);
        idle_inputs();
        flush = 1; en = 0; id_valid = 1; id_rs = 8; id_RegWr = 1; id_rdat2 = 32'h77;
        #1;
        total++; if (load_use !== 1'b1) begin bad++; $display("FAIL flush_precond got=%b exp=1", load_use); end
        tick();
        total++; if (ex_all !== '0) begin bad++; $display("FAIL flush_bubble got=%h exp=0", ex_all); end
        flush = 0; en = 1;
        tick();
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL flush_next_valid got=%b exp=1", ex_valid); end
        total++; if (ex_RegWr !== 1'b1) begin bad++; $display("FAIL flush_next_regwr got=%b exp=1", ex_RegWr); end
        total++; if (ex_rdat2 !== 32'h77) begin bad++; $display("FAIL flush_next_rdat2 got=%h exp=77", ex_rdat2); end
        total++; if (ex_rs !== 5'd8) begin bad++; $display("FAIL flush_next_rs got=%0d exp=8", ex_rs); end
        flush = 1; en = 1; id_halt = 1;
        tick();
        total++; if (ex_all !== '0) begin bad++; $display("FAIL flush_with_en got=%h exp=0", ex_all); end
    endtask

    initial begin
        test_reset();
        test_advance();
        test_load_use_rs();
        test_no_false_hazard();
        test_stall_hold();
        test_flush_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
